// File: rtl/mult_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl
// Purpose  : Multi-cycle MULT/MULTU sequencer that owns the architectural
//            HI/LO registers. An iterative shift-add engine retires
//            BITS_PER_CYCLE multiplier bits per clock. It stalls the core
//            when a HI/LO access collides with an in-flight multiply.
// Ports    : clk, rst_n (async, active low)
//            start, unsigned_instr, op1, op2  - multiply issue
//            acc_instr                        - MADD/MADDU (optional)
//            mthi, mtlo, wr_data              - HI/LO writes
//            mf_req                           - MFHI/MFLO issued this cycle
//            hi, lo                           - architectural registers
//            busy, done, stall                - status to the core
// Options  : define MULT_SEQ_ACC_EN to add acc_instr (multiply-accumulate)
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl #(
  parameter int BITS_PER_CYCLE = 1   // legal: 1, 2, 4, 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef MULT_SEQ_ACC_EN
  input  logic        acc_instr,
`endif
  input  logic        unsigned_instr,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int B = BITS_PER_CYCLE;
  localparam int N = 32 / B;
  localparam int W = 64 + B;   // product width plus guard bits

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;

  localparam logic [4:0] CNT_LOAD = 5'(N - 1);

  logic [1:0]    state;
  logic [4:0]    cnt;
  logic [31:0]   mcand;
  logic [31:0]   mplier;
  logic [W-1:0]  acc;
  logic          neg_flag;
`ifdef MULT_SEQ_ACC_EN
  logic          acc_flag;
`endif

  logic [31:0]   mag1;
  logic [31:0]   mag2;
  logic [31+B:0] partial;
  logic [31+B:0] sum_hi;
  logic [W-1:0]  acc_next;
  logic [63:0]   prod;
  logic [63:0]   result;
  logic [63:0]   wb_val;

  // Two's-complement magnitudes in signed mode; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  assign mag1 = (!unsigned_instr && op1[31]) ? (32'd0 - op1) : op1;
  assign mag2 = (!unsigned_instr && op2[31]) ? (32'd0 - op2) : op2;

  // Partial product of the multiplicand with the low B multiplier bits.
  assign partial = {{B{1'b0}}, mcand} * {{32{1'b0}}, mplier[B-1:0]};

  // Before each shift the running sum is below 2^(64+B), so the upper
  // 32+B bits absorb the addition without losing a carry.
  assign sum_hi   = acc[W-1:32] + partial;
  assign acc_next = {sum_hi, acc[31:0]} >> B;

  assign prod   = acc[63:0];
  assign result = neg_flag ? (64'd0 - prod) : prod;

`ifdef MULT_SEQ_ACC_EN
  assign wb_val = acc_flag ? ({hi, lo} + result) : result;
`else
  assign wb_val = result;
`endif

  assign busy  = (state != ST_IDLE);
  assign stall = busy & (start | mthi | mtlo | mf_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg_flag <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
      acc_flag <= 1'b0;
`endif
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_SIGN);
      case (state)
        ST_IDLE: begin
          if (start) begin
            // start takes priority over a same-cycle MTHI/MTLO
            mcand    <= mag1;
            mplier   <= mag2;
            neg_flag <= ~unsigned_instr & (op1[31] ^ op2[31]);
`ifdef MULT_SEQ_ACC_EN
            acc_flag <= acc_instr;
`endif
            acc      <= '0;
            cnt      <= CNT_LOAD;
            state    <= ST_RUN;
          end else begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
          end
        end
        ST_RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> B;
          if (cnt == 5'd0) begin
            state <= ST_SIGN;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_SIGN: begin
          {hi, lo} <= wb_val;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_ctrl
// Purpose  : Self-checking bench for mult_seq_ctrl. A cycle-level model built
//            from plain 64-bit arithmetic is compared with the DUT on every
//            falling edge; directed cases pin literal results and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_ctrl;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;
`ifdef MULT_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        unsigned_instr = 1'b0;
  logic        acc_in = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        mf_req = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
`ifdef MULT_SEQ_ACC_EN
    .acc_instr      (acc_in),
`endif
    .unsigned_instr (unsigned_instr),
    .op1            (op1),
    .op2            (op2),
    .mthi           (mthi),
    .mtlo           (mtlo),
    .wr_data        (wr_data),
    .mf_req         (mf_req),
    .hi             (hi),
    .lo             (lo),
    .busy           (busy),
    .done           (done),
    .stall          (stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic u, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (u) return {32'd0, a} * {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_done = 1'b0;
  int          m_left = 0;      // busy cycles still to come
  logic [63:0] m_pend = '0;
  logic        m_acc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0; m_pend <= '0; m_acc <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        {m_hi, m_lo} <= m_acc ? ({m_hi, m_lo} + m_pend) : m_pend;
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref_mul(unsigned_instr, op1, op2);
        m_left <= N + 1;
        m_acc  <= ACC_EN & acc_in;
      end else begin
        if (mthi) m_hi <= wr_data;
        if (mtlo) m_lo <= wr_data;
      end
    end
  end

  // Compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
    chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("stall", {63'd0, stall},
        {63'd0, (m_left > 0) && (start || mthi || mtlo || mf_req)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_op(input logic u, input logic ac, input logic [31:0] a,
                        input logic [31:0] b, input bit noise, input bit hz);
    start = 1'b1; unsigned_instr = u; acc_in = ac; op1 = a; op2 = b;
    for (int c = 1; c <= N + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
      if (noise && c <= N + 1) begin
        start = 1'($urandom_range(0, 1));
        mthi = 1'($urandom_range(0, 1));
        mtlo = 1'($urandom_range(0, 1));
        mf_req = 1'($urandom_range(0, 1));
        op1 = $urandom; op2 = $urandom; wr_data = $urandom;
        unsigned_instr = 1'($urandom_range(0, 1));
        acc_in = 1'($urandom_range(0, 1));
      end
      if (hz && c == 3) begin start = 1'b1; op1 = 32'd7; op2 = 32'd9; end
      if (hz && c == 5) begin mthi = 1'b1; wr_data = 32'hDEAD; end
      if (hz && (c == 7 || c == N + 2)) mf_req = 1'b1;
      #1;
      if (c <= N + 1) begin
        chk("lat_busy_high", {63'd0, busy}, 64'd1);
        chk("lat_done_low", {63'd0, done}, 64'd0);
      end
      if (hz && (c == 3 || c == 5 || c == 7))
        chk("hz_stall", {63'd0, stall}, 64'd1);
    end
    chk("lat_done_pulse", {63'd0, done}, 64'd1);
    chk("lat_busy_low", {63'd0, busy}, 64'd0);
    if (hz) chk("hz_mf_done_stall", {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, el});
    chk({name, "_model"}, {m_hi, m_lo}, {eh, el});
  endtask

  task automatic tick;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    expect_hilo("reset", 32'd0, 32'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);

    // Reset in RUN iteration 10 discards the multiply
    tick();
    start = 1'b1; unsigned_instr = 1'b1; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    expect_hilo("midrst", 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      chk("midrst_no_done", {63'd0, done}, 64'd0);
    end
    expect_hilo("midrst_after", 32'd0, 32'd0);

    // MULTU max x max
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    expect_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    // Signed cases, issued back to back in the done cycle
    run_op(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    expect_hilo("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    expect_hilo("mult_minxmin", 32'h4000_0000, 32'h0000_0000);
    run_op(1'b0, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    expect_hilo("mult_0xmin", 32'd0, 32'd0);

    // Idle MTHI/MTLO writes
    tick();
    mthi = 1'b1; wr_data = 32'h1234_5678;
    tick();
    chk("mthi_val", {32'd0, hi}, {32'd0, 32'h1234_5678});
    mtlo = 1'b1; wr_data = 32'h9ABC_DEF0;
    tick();
    chk("mtlo_val", {32'd0, lo}, {32'd0, 32'h9ABC_DEF0});
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h5555_AAAA;
    tick();
    expect_hilo("mt_both", 32'h5555_AAAA, 32'h5555_AAAA);

    // start wins over a same-cycle mtlo
    mtlo = 1'b1; wr_data = 32'h0000_AAAA;
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0);
    expect_hilo("start_mtlo", 32'd0, 32'd12);

    // Hazards while busy are stalled and ignored
    tick();
    run_op(1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 1'b1);
    expect_hilo("hazard", 32'd0, 32'h19);

`ifdef MULT_SEQ_ACC_EN
    tick();
    mthi = 1'b1; wr_data = 32'd0;
    tick();
    mtlo = 1'b1; wr_data = 32'hFFFF_FFFF;
    tick();
    run_op(1'b1, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    expect_hilo("maddu", 32'h0000_0001, 32'h0000_0000);
`endif

    // Randomized operations with noise on every input while busy
    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        mthi = 1'($urandom_range(0, 1));
        mtlo = 1'($urandom_range(0, 1));
        mf_req = 1'($urandom_range(0, 1));
        wr_data = $urandom;
      end
      if (gap > 0) tick();
      mthi = 1'b0; mtlo = 1'b0;
      run_op(1'($urandom_range(0, 1)), ACC_EN & 1'($urandom_range(0, 1)),
             $urandom, $urandom, 1'b1, 1'b0);
    end

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for the MIPS32 MULT/MULTU path. Owns the architectural HI/LO registers.
- Replaces the single-cycle 32x32 multiply with an iterative shift-add engine that handles BITS_PER_CYCLE multiplier bits per clock.
- Sits beside the ALU in the execute stage. Raises `stall` to the core when a HI/LO access collides with an in-flight multiply.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle. Legal values: 1, 2, 4, 8. N = 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue MULT/MULTU; sampled only in IDLE
- unsigned_instr  in  1  1 = MULTU, 0 = MULT (two's complement); latched with start
- op1  in  32  multiplicand (rs); latched with start
- op2  in  32  multiplier (rt); latched with start
- mthi  in  1  write wr_data to HI
- mtlo  in  1  write wr_data to LO
- wr_data  in  32  MTHI/MTLO data
- mf_req  in  1  decoder is issuing MFHI/MFLO this cycle
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  multiply in flight
- done  out  1  one-cycle pulse; hi/lo hold the new product
- stall  out  1  combinational: busy & (start | mthi | mtlo | mf_req)

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - hi, lo, busy and done are 0.
  - All internal accumulators, counters and latched operands are cleared.
  - An in-flight multiply is discarded and never writes HI/LO.
- FSM states: IDLE, RUN, SIGN.
- IDLE:
  - start=1 latches the operands and moves to RUN. The iteration counter is loaded with N-1.
  - Signed mode (unsigned_instr=0): each operand with bit31 set is replaced by its two's-complement magnitude. neg_flag = op1[31] ^ op2[31].
  - Unsigned mode: operands are taken as-is and neg_flag = 0.
  - A magnitude of 0x80000000 is valid as a 32-bit unsigned value.
- RUN:
  - Each cycle consumes the low BITS_PER_CYCLE bits of the multiplier magnitude.
  - The partial product (multiplicand magnitude x those bits) is added into the upper part of a 64-bit accumulator, then the accumulator and multiplier shift right by BITS_PER_CYCLE. No carry is lost; the accumulator is 64 bits plus BITS_PER_CYCLE guard bits.
  - When the counter reaches 0, move to SIGN.
- SIGN:
  - Result = neg_flag ? -acc[63:0] : acc[63:0] (64-bit two's complement).
  - {hi, lo} loads the result at the closing clock edge. Move to IDLE.
  - done is registered high for the following single cycle.
- Latency, with start in cycle 0:
  - busy is high in cycles 1..N+1.
  - done=1 and the new hi/lo are visible in cycle N+2. For BITS_PER_CYCLE=1 this is cycle 34.
  - A new start is accepted in cycle N+2, the same cycle as done.
- HI/LO writes:
  - mthi/mtlo in IDLE update hi/lo at the next edge. mthi and mtlo asserted together write both.
  - start together with mthi/mtlo in IDLE: start wins and the MT write is dropped. The decoder never issues both.
- While busy:
  - start, mthi and mtlo are ignored and raise stall.
  - mf_req raises stall.
  - The core holds the instruction until stall drops. Stall falls in cycle N+2, so MFHI/MFLO then reads the new product.
- Operands changing after the start cycle have no effect.

Optional Feature:
- Macro: MULT_SEQ_ACC_EN.
- When defined:
  - Adds input `acc_instr` (1 bit), latched with start.
  - When acc_instr=1 (MADD/MADDU), SIGN loads {hi, lo} with {hi, lo} + signed_result (64-bit wraparound) instead of the plain result. Latency is unchanged.
  - Undefined mtlo/mthi cannot occur mid-operation, because both are blocked while busy.
- When undefined: the port is absent and only MULT/MULTU behaviour exists.

Test Plan:
1. Reset:
   - Stimulus: rst_n low, then release.
   - Response: hi=lo=0, busy=0, done=0, stall=0.
   - Then assert rst_n low at RUN iteration 10 of a multiply: hi/lo stay 0, busy drops immediately, done never pulses.
2. MULTU, BITS_PER_CYCLE=1:
   - Stimulus: op1=op2=0xFFFFFFFF.
   - Response: hi=0xFFFFFFFE, lo=0x00000001. done in cycle 34, busy high in cycles 1..33.
3. MULT sign cases:
   - -3 x 7 gives hi=0xFFFFFFFF, lo=0xFFFFFFEB.
   - 0x80000000 x 0x80000000 gives hi=0x40000000, lo=0x00000000.
   - 0 x 0x80000000 gives 0/0.
4. Hazards, during busy:
   - Stimulus: pulse start (op1=5, op2=5), mthi (wr_data=0xDEAD), and mf_req.
   - Response: stall=1 for each and all are ignored. Final hi=0, lo=0x19. mf_req in the done cycle gives stall=0.
5. Idle writes:
   - Stimulus: mthi with 0x12345678, then mtlo with 0x9ABCDEF0.
   - Response: hi/lo show the values one edge later.
   - start and mtlo together in IDLE: the product is written and the mtlo value is dropped.
6. MULT_SEQ_ACC_EN:
   - Stimulus: hi=0, lo=0xFFFFFFFF, then MADDU 1 x 1.
   - Response: hi=0x00000001, lo=0x00000000.
   - With the macro undefined, the same test compiles with no acc_instr port.
